// File: rtl/universal_reg_file_mp.sv
// Byte-enabled register file with NUM_RD_PORTS registered read ports and a one-entry-per-cycle bulk clear.
// Read latency 1 cycle; no backpressure: writes arriving while busy are dropped, reads are always served.
module universal_reg_file_mp #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 16,
    parameter int NUM_RD_PORTS = 2,
    parameter int BYPASS       = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int BE_W   = DATA_WIDTH / 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic [ADDR_W-1:0]                    wr_addr,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    input  logic [BE_W-1:0]                      wr_be,
    input  logic [NUM_RD_PORTS-1:0]              rd_en,
    input  logic [NUM_RD_PORTS*ADDR_W-1:0]       rd_addr,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_RD_PORTS-1:0]              rd_valid,
    input  logic                                 clr_req,
    output logic                                 busy,
    output logic                                 clr_done,
    output logic                                 addr_err
);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    state_t                state_q;
    logic [ADDR_W-1:0]     cnt_q;
    logic                  clr_done_q;
    logic                  addr_err_q;
    logic [NUM_RD_PORTS-1:0]                 rd_valid_q;
    logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] rd_data_q;

    logic                  wr_in_range;
    logic                  wr_commit;
    logic [ADDR_W-1:0]     wr_idx;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [DATA_WIDTH-1:0] rd_word [NUM_RD_PORTS];
    logic [NUM_RD_PORTS-1:0] rd_oob;
    logic                  err_d;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_X);
    assign wr_commit   = (state_q == ST_IDLE) && wr_en && wr_in_range;
    assign wr_idx      = wr_in_range ? wr_addr : '0;

    always_comb begin
        wr_merged = mem_q[wr_idx];
        for (int k = 0; k < BE_W; k++) begin
            if (wr_be[k]) wr_merged[8*k +: 8] = wr_data[8*k +: 8];
        end
    end

    // Clear-engine writes are never forwarded; only a committing host write is.
    always_comb begin
        rd_oob = '0;
        for (int i = 0; i < NUM_RD_PORTS; i++) begin
            rd_word[i] = '0;
            if ({1'b0, rd_addr[i*ADDR_W +: ADDR_W]} >= DEPTH_X) begin
                rd_oob[i] = 1'b1;
            end else if ((BYPASS != 0) && wr_commit && (rd_addr[i*ADDR_W +: ADDR_W] == wr_addr)) begin
                rd_word[i] = wr_merged;
            end else begin
                rd_word[i] = mem_q[rd_addr[i*ADDR_W +: ADDR_W]];
            end
        end
    end

    assign err_d = (|(rd_en & rd_oob)) || ((state_q == ST_IDLE) && wr_en && !wr_in_range);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int e = 0; e < DEPTH; e++) mem_q[e] <= RESET_VAL;
        end else if (state_q == ST_CLEAR) begin
            mem_q[cnt_q] <= RESET_VAL;
        end else if (wr_commit) begin
            mem_q[wr_addr] <= wr_merged;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_en;
            for (int i = 0; i < NUM_RD_PORTS; i++) begin
                if (rd_en[i]) rd_data_q[i] <= rd_word[i];
            end
        end
    end

    // clr_done is raised on the edge that loads the last index, so it coincides with the final busy cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            clr_done_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            clr_done_q <= 1'b0;
            addr_err_q <= err_d;
            case (state_q)
                ST_IDLE: begin
                    if (clr_req) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_q == LAST_IDX) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q      <= cnt_q + 1'b1;
                        clr_done_q <= ((cnt_q + 1'b1) == LAST_IDX);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (state_q == ST_CLEAR);
    assign clr_done = clr_done_q;
    assign addr_err = addr_err_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_universal_reg_file_mp.sv
// Bench for universal_reg_file_mp: default instance scoreboarded every cycle, plus BYPASS=0 and DEPTH=12 instances.
module tb_universal_reg_file_mp;

    logic clk;
    logic rst;
    logic        wr_en, clr_req;
    logic [3:0]  wr_addr, wr_be;
    logic [31:0] wr_data;
    logic [1:0]  rd_en, rd_valid;
    logic [7:0]  rd_addr;
    logic [63:0] rd_data;
    logic        busy, clr_done, addr_err;

    logic        a_wr_en, a_clr_req;
    logic [3:0]  a_wr_addr, a_wr_be;
    logic [31:0] a_wr_data;
    logic [1:0]  a_rd_en;
    logic [7:0]  a_rd_addr;
    logic [63:0] nb_rd_data, d_rd_data;
    logic [1:0]  nb_rd_valid, d_rd_valid;
    logic        nb_busy, nb_done, nb_err, d_busy, d_done, d_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    universal_reg_file_mp dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .clr_req(clr_req), .busy(busy), .clr_done(clr_done), .addr_err(addr_err)
    );

    universal_reg_file_mp #(.BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_be(a_wr_be),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(nb_rd_data), .rd_valid(nb_rd_valid),
        .clr_req(a_clr_req), .busy(nb_busy), .clr_done(nb_done), .addr_err(nb_err)
    );

    universal_reg_file_mp #(.DEPTH(12)) u_d12 (
        .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_be(a_wr_be),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(d_rd_data), .rd_valid(d_rd_valid),
        .clr_req(a_clr_req), .busy(d_busy), .clr_done(d_done), .addr_err(d_err)
    );

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        clr;
        logic [1:0]  re;
        logic [3:0]  ra0, ra1;
        logic [31:0] e0, e1;
        logic        bsy, dn;
    } vec_t;

    typedef struct {
        logic [1:0]  vld;
        logic [31:0] d0, d1;
        logic        bsy, dn;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] hold0, hold1;
    int          checks;
    int          failures;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                                input logic [3:0] be, input logic clr, input logic [1:0] re,
                                input logic [3:0] ra0, input logic [3:0] ra1,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic bsy, input logic dn);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.be = be; v.clr = clr; v.re = re;
        v.ra0 = ra0; v.ra1 = ra1; v.e0 = e0; v.e1 = e1; v.bsy = bsy; v.dn = dn;
        return v;
    endfunction

    task automatic check_main();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
        end else begin
            e.vld = 2'b00; e.d0 = hold0; e.d1 = hold1; e.bsy = 1'b0; e.dn = 1'b0;
        end
        cmp("rd_valid", 64'(rd_valid), 64'(e.vld));
        cmp("rd_data0", 64'(rd_data[31:0]), 64'(e.d0));
        cmp("rd_data1", 64'(rd_data[63:32]), 64'(e.d1));
        cmp("busy", 64'(busy), 64'(e.bsy));
        cmp("clr_done", 64'(clr_done), 64'(e.dn));
        cmp("addr_err", 64'(addr_err), 64'd0);
    endtask

    // Check the outputs produced by the previous edge, then drive this cycle and queue its expectation.
    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        check_main();
        wr_en = v.we; wr_addr = v.wa; wr_data = v.wd; wr_be = v.be; clr_req = v.clr;
        rd_en = v.re; rd_addr = {v.ra1, v.ra0};
        e.vld = v.re;
        e.d0  = v.re[0] ? v.e0 : hold0;
        e.d1  = v.re[1] ? v.e1 : hold1;
        e.bsy = v.bsy;
        e.dn  = v.dn;
        hold0 = e.d0;
        hold1 = e.d1;
        sb.push_back(e);
    endtask

    task automatic idle_main();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0; clr_req = 1'b0; rd_en = '0; rd_addr = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        vec_t v;
        checks = 0; failures = 0; hold0 = '0; hold1 = '0;

        tbl[0] = mk(1'b1, 4'd3,  32'hDEADBEEF, 4'hF, 1'b0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        tbl[1] = mk(1'b1, 4'd3,  32'h11223344, 4'h5, 1'b0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        tbl[2] = mk(1'b0, 4'd0,  32'h0,        4'h0, 1'b0, 2'b01, 4'd3, 4'd0, 32'hDE22BE44, 32'h0, 1'b0, 1'b0);
        tbl[3] = mk(1'b1, 4'd5,  32'hA5A5A5A5, 4'hF, 1'b0, 2'b10, 4'd0, 4'd5, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0);
        tbl[4] = mk(1'b1, 4'd5,  32'h00000000, 4'h0, 1'b0, 2'b11, 4'd5, 4'd3, 32'hA5A5A5A5, 32'hDE22BE44, 1'b0, 1'b0);
        tbl[5] = mk(1'b1, 4'd7,  32'h12345678, 4'hC, 1'b0, 2'b11, 4'd7, 4'd7, 32'h12340000, 32'h12340000, 1'b0, 1'b0);
        tbl[6] = mk(1'b0, 4'd0,  32'h0,        4'h0, 1'b0, 2'b11, 4'd7, 4'd5, 32'h12340000, 32'hA5A5A5A5, 1'b0, 1'b0);
        tbl[7] = mk(1'b1, 4'd0,  32'hCAFEF00D, 4'h3, 1'b0, 2'b01, 4'd0, 4'd0, 32'h0000F00D, 32'h0, 1'b0, 1'b0);
        tbl[8] = mk(1'b1, 4'd15, 32'hFFFFFFFF, 4'hF, 1'b0, 2'b10, 4'd0, 4'd15, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0);
        tbl[9] = mk(1'b0, 4'd0,  32'h0,        4'h0, 1'b0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0);

        rst = 1'b0;
        idle_main();
        a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_wr_be = '0; a_rd_en = '0; a_rd_addr = '0; a_clr_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++)
            apply(mk(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 2'b11, i[3:0], 4'(15 - i), 32'h0, 32'h0, 1'b0, 1'b0));
        apply(tbl[9]);

        for (int i = 0; i < 10; i++) apply(tbl[i]);

        @(negedge clk);
        a_wr_en = 1'b1; a_wr_addr = 4'd5; a_wr_data = 32'hA5A5A5A5; a_wr_be = 4'hF;
        a_rd_en = 2'b10; a_rd_addr = {4'd5, 4'd0};
        @(posedge clk); #1;
        cmp("nb_same_cycle_old", 64'(nb_rd_data[63:32]), 64'h0);
        cmp("nb_valid", 64'(nb_rd_valid), 64'(2'b10));
        cmp("d12_same_cycle_bypass", 64'(d_rd_data[63:32]), 64'hA5A5A5A5);
        @(negedge clk);
        a_wr_addr = 4'd13; a_wr_data = 32'h11111111; a_rd_en = 2'b01; a_rd_addr = {4'd0, 4'd14};
        @(posedge clk); #1;
        cmp("d12_oob_data", 64'(d_rd_data[31:0]), 64'h0);
        cmp("d12_oob_valid", 64'(d_rd_valid), 64'(2'b01));
        cmp("d12_addr_err", 64'(d_err), 64'd1);
        cmp("nb_in_range_no_err", 64'(nb_err), 64'd0);
        @(negedge clk);
        a_wr_en = 1'b0; a_rd_en = 2'b11; a_rd_addr = {4'd5, 4'd1};
        @(posedge clk); #1;
        cmp("d12_err_one_cycle", 64'(d_err), 64'd0);
        cmp("d12_addr1_untouched", 64'(d_rd_data[31:0]), 64'h0);
        cmp("d12_addr5_untouched", 64'(d_rd_data[63:32]), 64'hA5A5A5A5);
        cmp("nb_write_committed", 64'(nb_rd_data[63:32]), 64'hA5A5A5A5);
        @(negedge clk);
        a_rd_en = 2'b00;

        for (int i = 0; i < 16; i++)
            apply(mk(1'b1, i[3:0], 32'hFFFFFFFF, 4'hF, 1'b0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0));

        for (int j = 0; j < 18; j++) begin
            v = mk(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, (j < 16), (j == 15));
            if (j == 0) begin v.we = 1'b1; v.wa = 4'd2; v.wd = 32'h0000BEEF; v.be = 4'hF; v.clr = 1'b1; end
            if (j == 5) begin v.we = 1'b1; v.wa = 4'd0; v.wd = 32'h12345678; v.be = 4'hF; end
            if (j == 8) v.clr = 1'b1;
            case (j)
                1:       begin v.re = 2'b11; v.ra0 = 4'd0; v.e0 = 32'hFFFFFFFF; v.ra1 = 4'd2; v.e1 = 32'h0000BEEF; end
                3, 6:    begin v.re = 2'b11; v.ra0 = 4'd0; v.e0 = 32'h0; v.ra1 = 4'd15; v.e1 = 32'hFFFFFFFF; end
                16:      begin v.re = 2'b10; v.ra1 = 4'd15; v.e1 = 32'hFFFFFFFF; end
                17:      begin v.re = 2'b11; v.ra0 = 4'd0; v.e0 = 32'h0; v.ra1 = 4'd15; v.e1 = 32'h0; end
                default: ;
            endcase
            apply(v);
        end

        for (int k = 0; k < 23; k++) begin
            v = mk(1'b0, 4'd0, 32'h0, 4'h0, (k <= 17), 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, (k != 16), (k == 15));
            if (k == 17) begin v.we = 1'b1; v.wa = 4'd9; v.wd = 32'h55AA55AA; v.be = 4'hF; end
            if (k == 22) begin v.re = 2'b11; v.ra0 = 4'd9; v.e0 = 32'h55AA55AA; v.ra1 = 4'd3; v.e1 = 32'h0; end
            apply(v);
        end

        @(posedge clk); #1;
        cmp("busy_before_reset", 64'(busy), 64'd1);
        cmp("valid_before_reset", 64'(rd_valid), 64'(2'b11));
        #1;
        rst = 1'b0;
        idle_main();
        #1;
        cmp("reset_busy", 64'(busy), 64'd0);
        cmp("reset_valid", 64'(rd_valid), 64'd0);
        cmp("reset_addr_err", 64'(addr_err), 64'd0);
        cmp("reset_clr_done", 64'(clr_done), 64'd0);
        cmp("reset_rd_data", rd_data, 64'h0);
        sb.delete();
        hold0 = '0;
        hold1 = '0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++)
            apply(mk(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 2'b11, i[3:0], 4'(i + 9), 32'h0, 32'h0, 1'b0, 1'b0));
        for (int i = 0; i < 18; i++) apply(tbl[9]);
        @(negedge clk);
        check_main();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
